// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receiver FSM state encoding,
// bit-timing derivation helpers and the frame data width.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Number of system clocks spanned by one serial bit (integer division).
    function automatic int clks_per_bit(input int clockFreq, input int baudRate);
        return clockFreq / baudRate;
    endfunction

    // Middle of a bit period, in clocks.
    function automatic int half_bit(input int clksPerBit);
        return clksPerBit / 2;
    endfunction

    // Two-out-of-three vote used to reject single-sample noise on the line.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always
// presented on rd_data_o; rd_en_i consumes it. A write into a full FIFO is
// accepted only when a read happens in the same cycle.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   wr_en_i    write request
//   wr_data_i  data to write
//   rd_en_i    read (pop) request, ignored while empty
//   rd_data_o  head entry
//   full_o     FIFO holds DEPTH entries
//   empty_o    FIFO holds no entries
//   count_o    number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             doWrite;
    logic             doRead;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rdPtr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign doRead  = rd_en_i && !empty_o;
    assign doWrite = wr_en_i && (!full_o || doRead);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = doWrite ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = doRead  ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d = count_q;
        if (doWrite && !doRead) begin
            count_d = count_q + 1'b1;
        end else if (!doWrite && doRead) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage and bookkeeping registers; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (doWrite) begin
                mem_q[wrPtr_q] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// ---------------------------------------------------------------------------
// uart_rx_buffered
// 8N1 UART receiver with a receive FIFO. The serial input is synchronised,
// each bit is decided by a three-sample majority vote around mid-bit, and
// good bytes are queued for the consumer, which drains them with a
// valid/ready handshake.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx           serial line, idle high, asynchronous to clk
//   rx_data      byte at FIFO head
//   rx_valid     FIFO non-empty
//   rx_ready     consumer accepts the head when rx_valid is high
//   fifo_count   bytes currently stored
//   frame_error  one-cycle pulse on a bad stop bit
//   overrun      one-cycle pulse when a good byte is dropped on a full FIFO
// ---------------------------------------------------------------------------
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ  = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int BUFFER_SIZE = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(BUFFER_SIZE):0]  fifo_count,
    output logic                          frame_error,
    output logic                          overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF         = half_bit(CLKS_PER_BIT);
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] SAMPLE_A = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SAMPLE_B = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic                 rxMeta_q;
    logic                 rxSync_q;
    logic [1:0]           syncFill_q;
    logic                 rxHigh_q;
    logic [CNT_W-1:0]     bitCnt_q;
    logic [IDX_W-1:0]     bitIdx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 sampleA_q;
    logic                 sampleB_q;
    logic                 frameError_q;
    logic                 overrun_q;

    logic                 vote;
    logic                 atDecide;
    logic                 push;
    logic                 fifoFull;
    logic                 fifoEmpty;

    assign vote     = majority3(sampleA_q, sampleB_q, rxSync_q);
    assign atDecide = (bitCnt_q == SAMPLE_C);
    assign push     = (state_q == STOP) && atDecide && vote;

    assign rx_valid    = !fifoEmpty;
    assign frame_error = frameError_q;
    assign overrun     = overrun_q;

    // Synchroniser, bit timing and frame FSM. syncFill_q marks when the
    // synchroniser holds real line samples rather than its reset value, so a
    // line held low through reset release is not taken as a start bit.
    // The bit counter keeps its phase from the start-bit decision onward, so
    // every later decision lands at the same mid-bit offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rxMeta_q     <= 1'b1;
            rxSync_q     <= 1'b1;
            syncFill_q   <= 2'b00;
            rxHigh_q     <= 1'b0;
            bitCnt_q     <= '0;
            bitIdx_q     <= '0;
            shift_q      <= '0;
            sampleA_q    <= 1'b1;
            sampleB_q    <= 1'b1;
            frameError_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rxMeta_q     <= rx;
            rxSync_q     <= rxMeta_q;
            syncFill_q   <= {syncFill_q[0], 1'b1};
            rxHigh_q     <= syncFill_q[1] & rxSync_q;
            frameError_q <= 1'b0;
            overrun_q    <= push && fifoFull && !rx_ready;

            bitCnt_q <= (bitCnt_q == LAST_CNT) ? '0 : bitCnt_q + 1'b1;
            if (bitCnt_q == SAMPLE_A) begin
                sampleA_q <= rxSync_q;
            end
            if (bitCnt_q == SAMPLE_B) begin
                sampleB_q <= rxSync_q;
            end

            case (state_q)
                IDLE: begin
                    if (rxHigh_q && !rxSync_q) begin
                        bitCnt_q <= '0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (atDecide) begin
                        if (vote) begin
                            state_q <= IDLE;
                        end else begin
                            bitIdx_q <= '0;
                            state_q  <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (atDecide) begin
                        shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                        if (bitIdx_q == LAST_BIT) begin
                            state_q <= STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (atDecide) begin
                        if (vote) begin
                            state_q <= IDLE;
                        end else begin
                            frameError_q <= 1'b1;
                            state_q      <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxSync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(BUFFER_SIZE)
    ) rxFifo (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (push),
        .wr_data_i (shift_q),
        .rd_en_i   (rx_ready),
        .rd_data_o (rx_data),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty),
        .count_o   (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_buffered
// Directed bench for uart_rx_buffered at 10 clocks per bit with a 4-entry
// FIFO. Frames are driven one clock after the rising edge and outputs are
// sampled at the same point, so the stop-bit decision cycle of a frame is
// the last clock of its stop bit.
// ---------------------------------------------------------------------------
module tb_uart_rx_buffered;

    localparam int CLOCK_FREQ  = 1000000;
    localparam int BAUD_RATE   = 100000;
    localparam int BUFFER_SIZE = 4;
    localparam int BIT_CLKS    = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       frame_error;
    logic       overrun;

    int vectorCount = 0;
    int missCount   = 0;
    int errPulses   = 0;
    int ovrPulses   = 0;
    int errBefore;
    int ovrBefore;

    logic [7:0] burst [4];
    logic [7:0] fill  [4];
    logic [7:0] drain [4];
    logic [7:0] partial;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLOCK_FREQ  (CLOCK_FREQ),
        .BAUD_RATE   (BAUD_RATE),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fifo_count  (fifo_count),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    // Count every pulse so single-cycle behaviour can be checked after the fact.
    always @(posedge clk) begin
        if (frame_error) errPulses <= errPulses + 1;
        if (overrun)     ovrPulses <= ovrPulses + 1;
    end

    task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic driveLevel(input logic level, input int n);
        rx = level;
        tick(n);
    endtask

    // One 8N1 frame. glitchBit selects a data bit that gets a one-clock
    // inverted pulse at its middle sample (-1 for none); stopClks lets a test
    // stop inside the stop-bit decision cycle (9) instead of after it (10).
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int glitchBit, input int stopClks);
        driveLevel(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (i == glitchBit) begin
                driveLevel(data[i], 6);
                driveLevel(~data[i], 1);
                driveLevel(data[i], 3);
            end else begin
                driveLevel(data[i], BIT_CLKS);
            end
        end
        driveLevel(stopBit, stopClks);
    endtask

    task automatic popOne();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        burst = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        fill  = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain = '{8'h22, 8'h33, 8'h44, 8'h99};

        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        checkOutput("reset_valid", 32'(rx_valid), 0);
        checkOutput("reset_data", 32'(rx_data), 0);
        checkOutput("reset_count", 32'(fifo_count), 0);
        checkOutput("reset_ferr", 32'(frame_error), 0);
        checkOutput("reset_ovr", 32'(overrun), 0);
        rst_n = 1'b1;
        tick(5);

        // Single frame: valid appears exactly one cycle after the stop decision.
        applyStimulus(8'hA5, 1'b1, -1, 9);
        checkOutput("a5_valid_before_push", 32'(rx_valid), 0);
        tick(1);
        checkOutput("a5_valid", 32'(rx_valid), 1);
        checkOutput("a5_data", 32'(rx_data), 32'h A5);
        checkOutput("a5_count", 32'(fifo_count), 1);
        popOne();
        checkOutput("a5_pop_valid", 32'(rx_valid), 0);
        checkOutput("a5_pop_count", 32'(fifo_count), 0);
        rx_ready = 1'b1;
        tick(2);
        rx_ready = 1'b0;
        checkOutput("empty_ready_count", 32'(fifo_count), 0);

        // Fill the FIFO back-to-back, then overflow it.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(burst[i], 1'b1, -1, BIT_CLKS);
        end
        checkOutput("burst_count", 32'(fifo_count), 4);
        ovrBefore = ovrPulses;
        applyStimulus(8'h81, 1'b1, -1, BIT_CLKS);
        checkOutput("ovr_pulse", 32'(overrun), 1);
        checkOutput("ovr_count", 32'(fifo_count), 4);
        checkOutput("ovr_head", 32'(rx_data), 32'h00);
        tick(1);
        checkOutput("ovr_pulse_end", 32'(overrun), 0);
        checkOutput("ovr_pulse_count", 32'(ovrPulses - ovrBefore), 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("burst_valid_%0d", i), 32'(rx_valid), 1);
            checkOutput($sformatf("burst_data_%0d", i), 32'(rx_data), 32'(burst[i]));
            popOne();
        end
        checkOutput("burst_drained", 32'(rx_valid), 0);

        // Bad stop bit followed by a held-low line, then a clean frame.
        errBefore = errPulses;
        applyStimulus(8'h12, 1'b0, -1, BIT_CLKS);
        checkOutput("ferr_pulse", 32'(frame_error), 1);
        checkOutput("ferr_count", 32'(fifo_count), 0);
        tick(1);
        checkOutput("ferr_pulse_end", 32'(frame_error), 0);
        driveLevel(1'b0, 30);
        driveLevel(1'b1, 10);
        checkOutput("ferr_pulse_count", 32'(errPulses - errBefore), 1);
        applyStimulus(8'h34, 1'b1, -1, BIT_CLKS);
        checkOutput("after_break_data", 32'(rx_data), 32'h34);
        checkOutput("after_break_count", 32'(fifo_count), 1);
        popOne();

        // Short low glitch on an idle line is rejected.
        errBefore = errPulses;
        driveLevel(1'b0, 3);
        driveLevel(1'b1, 20);
        checkOutput("glitch_count", 32'(fifo_count), 0);
        checkOutput("glitch_ferr", 32'(errPulses - errBefore), 0);
        applyStimulus(8'h7E, 1'b1, -1, BIT_CLKS);
        checkOutput("post_glitch_data", 32'(rx_data), 32'h7E);
        checkOutput("post_glitch_count", 32'(fifo_count), 1);
        popOne();

        // One-clock glitch inside data bit 3 is outvoted.
        applyStimulus(8'hF0, 1'b1, 3, BIT_CLKS);
        checkOutput("vote_data", 32'(rx_data), 32'hF0);
        checkOutput("vote_count", 32'(fifo_count), 1);
        popOne();

        // Full FIFO: push and pop in the same cycle both succeed.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(fill[i], 1'b1, -1, BIT_CLKS);
        end
        checkOutput("fill_count", 32'(fifo_count), 4);
        ovrBefore = ovrPulses;
        applyStimulus(8'h99, 1'b1, -1, 9);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        checkOutput("swap_ovr", 32'(overrun), 0);
        checkOutput("swap_count", 32'(fifo_count), 4);
        tick(1);
        checkOutput("swap_ovr_pulses", 32'(ovrPulses - ovrBefore), 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("swap_data_%0d", i), 32'(rx_data), 32'(drain[i]));
            popOne();
        end
        checkOutput("swap_drained", 32'(fifo_count), 0);

        // Reset in the middle of a frame with data buffered.
        applyStimulus(8'h5A, 1'b1, -1, BIT_CLKS);
        checkOutput("prereset_count", 32'(fifo_count), 1);
        partial = 8'hC3;
        driveLevel(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            driveLevel(partial[i], BIT_CLKS);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        checkOutput("midreset_valid", 32'(rx_valid), 0);
        checkOutput("midreset_data", 32'(rx_data), 0);
        checkOutput("midreset_count", 32'(fifo_count), 0);
        checkOutput("midreset_ferr", 32'(frame_error), 0);
        checkOutput("midreset_ovr", 32'(overrun), 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        applyStimulus(8'h6B, 1'b1, -1, BIT_CLKS);
        checkOutput("postreset_valid", 32'(rx_valid), 1);
        checkOutput("postreset_data", 32'(rx_data), 32'h6B);
        checkOutput("postreset_count", 32'(fifo_count), 1);
        popOne();
        checkOutput("postreset_empty", 32'(rx_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
